// File: rtl/kalman_pkg.sv
// Shared types and constants for the Kalman-gain divider.
package kalman_pkg;

    typedef enum logic [1:0] {IDLE, SUM, DIV, DONE} state_t;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_FRAC  = 16;
    localparam logic [DEF_WIDTH-1:0] ONE = DEF_WIDTH'(1) << DEF_FRAC;

    // Iteration counter must hold WIDTH+FRAC+1 (rounding build)
    function automatic int unsigned iter_cnt_w(input int unsigned width, input int unsigned frac);
        return $clog2(width + frac + 2);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0] i_rem,
    input  logic           i_bit,
    input  logic [WIDTH:0] i_div,
    output logic [WIDTH:0] o_rem,
    output logic           o_q
);

    logic [WIDTH+1:0] w_ext;
    logic [WIDTH:0]   w_diff;

    // i_rem < i_div, so the true difference always fits in WIDTH+1 bits
    always_comb begin
        w_ext  = {i_rem, i_bit};
        w_diff = w_ext[WIDTH:0] - i_div;
        o_q    = (w_ext >= {1'b0, i_div});
        o_rem  = o_q ? w_diff : w_ext[WIDTH:0];
    end

endmodule

// File: rtl/kalman_gain.sv
// Sequential gain k = p / (p + r) via a bit-serial restoring divider.
// Define KGAIN_ROUND_EN to compute one extra quotient bit and round half-up.
module kalman_gain
    import kalman_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned FRAC  = DEF_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_k,
    output logic             out_dz
);

`ifdef KGAIN_ROUND_EN
    localparam int unsigned N  = WIDTH + FRAC + 1;
    localparam int unsigned QW = WIDTH + 1;
`else
    localparam int unsigned N  = WIDTH + FRAC;
    localparam int unsigned QW = WIDTH;
`endif
    localparam int unsigned   CW    = iter_cnt_w(WIDTH, FRAC);
    localparam logic [CW-1:0] N_CNT = CW'(N);

    state_t          r_state, w_state_next;
    logic [WIDTH-1:0] r_p, r_r, r_k, w_k;
    logic [WIDTH:0]   r_s, r_rem, w_rem_next, w_sum;
    logic [N-1:0]     r_dvd;
    logic [QW-2:0]    r_q;
    logic [QW-1:0]    w_q_next;
    logic [CW-1:0]    r_cnt;
    logic             w_qbit, r_dz, r_valid;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem (r_rem),
        .i_bit (r_dvd[N-1]),
        .i_div (r_s),
        .o_rem (w_rem_next),
        .o_q   (w_qbit)
    );

    always_comb begin
        w_sum    = {1'b0, r_p} + {1'b0, r_r};
        w_q_next = {r_q, w_qbit};
`ifdef KGAIN_ROUND_EN
        // (q + 1) >> 1 == (q >> 1) + q[0]
        w_k = w_q_next[WIDTH:1] + {{(WIDTH-1){1'b0}}, w_q_next[0]};
`else
        w_k = w_q_next;
`endif
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (in_valid) w_state_next = SUM;
            SUM:  w_state_next = (w_sum == '0) ? DONE : DIV;
            DIV:  if (r_cnt == CW'(1)) w_state_next = DONE;
            DONE: if (r_valid && out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_p     <= '0;
            r_r     <= '0;
            r_s     <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_k     <= '0;
            r_dz    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_p <= p;
                        r_r <= r;
                    end
                end
                SUM: begin
                    r_s   <= w_sum;
                    r_rem <= '0;
                    r_dvd <= {r_p, {(N-WIDTH){1'b0}}};
                    r_q   <= '0;
                    r_cnt <= N_CNT;
                    r_k   <= '0;
                    r_dz  <= (w_sum == '0);
                end
                DIV: begin
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[N-2:0], 1'b0};
                    r_q   <= w_q_next[QW-2:0];
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_k     <= w_k;
                        r_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Divide-by-zero enters DONE straight from SUM; its valid lands one edge later
                    if (!r_valid)      r_valid <= 1'b1;
                    else if (out_ready) r_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_valid;
    assign out_k     = r_k;
    assign out_dz    = r_dz;

endmodule

// File: tb/tb_kalman_gain.sv
// Directed-vector bench for kalman_gain (truncating or KGAIN_ROUND_EN build).
module tb_kalman_gain;

`ifdef KGAIN_ROUND_EN
    localparam int LAT = 50;
    localparam logic [31:0] K_2_1 = 32'h0000_AAAB;
`else
    localparam int LAT = 49;
    localparam logic [31:0] K_2_1 = 32'h0000_AAAA;
`endif

    typedef struct {
        logic [31:0] p;
        logic [31:0] r;
        logic [31:0] k;
        logic        dz;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] p = '0;
    logic [31:0] r = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_k;
    logic        out_dz;

    int n_cmp = 0;
    int n_err = 0;

    kalman_gain #(.WIDTH(32), .FRAC(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_k     (out_k),
        .out_dz    (out_dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called #1 after a posedge; returns result and edges from accept to out_valid
    task automatic do_op(input logic [31:0] ip, input logic [31:0] ir,
                         output logic [31:0] ok, output logic odz, output int olat);
        check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        p = ip;
        r = ir;
        @(posedge clk); #1;
        in_valid = 1'b0;
        p = $urandom;
        r = $urandom;
        olat = 0;
        while (!out_valid && olat < 200) begin
            @(posedge clk); #1;
            olat++;
        end
        ok  = out_k;
        odz = out_dz;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs[8];
        logic [31:0] k;
        logic        dz;
        int          lat;
        int          unstable;

        vecs[0] = '{32'd1, 32'd1, 32'h0000_8000, 1'b0, LAT};
        vecs[1] = '{32'd3, 32'd1, 32'h0000_C000, 1'b0, LAT};
        vecs[2] = '{32'd0, 32'd5, 32'h0000_0000, 1'b0, LAT};
        vecs[3] = '{32'd0, 32'd0, 32'h0000_0000, 1'b1, 2};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_8000, 1'b0, LAT};
        vecs[5] = '{32'd2, 32'd1, K_2_1, 1'b0, LAT};
        vecs[6] = '{32'd1, 32'd2, 32'h0000_5555, 1'b0, LAT};
        vecs[7] = '{32'd1, 32'd3, 32'h0000_4000, 1'b0, LAT};

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out_k", {32'd0, out_k}, 64'd0);
        check("reset_out_dz", {63'd0, out_dz}, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].p, vecs[i].r, k, dz, lat);
            check($sformatf("vec%0d_k", i), {32'd0, k}, {32'd0, vecs[i].k});
            check($sformatf("vec%0d_dz", i), {63'd0, dz}, {63'd0, vecs[i].dz});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            release_out();
            check($sformatf("vec%0d_valid_cleared", i), {63'd0, out_valid}, 64'd0);
        end

        // Backpressure: hold the result for 10 cycles
        do_op(32'd3, 32'd1, k, dz, lat);
        check("bp_k", {32'd0, k}, 64'h0000_C000);
        unstable = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_k !== 32'h0000_C000 || in_ready !== 1'b0) unstable++;
        end
        check("bp_hold_stable_cycles", 64'(unstable), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_in_ready_after", {63'd0, in_ready}, 64'd1);
        check("bp_valid_after", {63'd0, out_valid}, 64'd0);
        do_op(32'd1, 32'd1, k, dz, lat);
        check("bp_second_k", {32'd0, k}, 64'h0000_8000);
        check("bp_second_latency", 64'(lat), 64'(LAT));
        release_out();

        // Reset at division step 20
        in_valid = 1'b1;
        p = 32'd5;
        r = 32'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_out_k", {32'd0, out_k}, 64'd0);
        check("midrst_out_dz", {63'd0, out_dz}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        do_op(32'd1, 32'd3, k, dz, lat);
        check("midrst_fresh_k", {32'd0, k}, 64'h0000_4000);
        check("midrst_fresh_latency", 64'(lat), 64'(LAT));
        release_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/kalman_gain.md
# kalman_gain

Sequential Kalman-gain unit for the filter datapath. It computes k = p / (p + r) as an unsigned fixed-point fraction using a one-bit-per-cycle restoring divider. It sits downstream of the multiply/add covariance-prediction stage, which supplies p, and upstream of the state-update stage, which consumes k. Its sequencing is the inverse direction of the multiply-accumulate block: it divides rather than multiplies, and uses a valid/ready handshake on both sides.

## Interface

Parameters:
- WIDTH, default 32: width of the p and r operands and of the out_k result.
- FRAC, default 16: number of fractional bits in out_k; 1.0 is represented as 1 << FRAC.

Ports (clock and reset first):
- clk  in  1  the single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  p and r are valid this cycle.
- in_ready  out  1  the block accepts operands; high exactly when the state is IDLE.
- p  in  WIDTH  predicted covariance, unsigned integer.
- r  in  WIDTH  measurement noise, unsigned integer.
- out_valid  out  1  out_k and out_dz are valid.
- out_ready  in  1  the consumer takes the result.
- out_k  out  WIDTH  gain in unsigned Q(WIDTH-FRAC).FRAC format.
- out_dz  out  1  divide-by-zero flag (p + r == 0).

## Operation

- States: IDLE, SUM, DIV, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, capture p and r and go to SUM.
- SUM:
  - Compute s = p + r at WIDTH+1 bits, so the sum never overflows.
  - If s == 0: set out_k = 0, out_dz = 1, go to DONE.
  - Otherwise: load dividend {p, FRAC'b0} (WIDTH+FRAC bits), clear the remainder (WIDTH+1 bits), load iteration count N, go to DIV.
- DIV, one restoring step per cycle:
  - rem' = {rem, next dividend MSB}.
  - If rem' >= s, subtract s and shift in a quotient bit of 1; otherwise shift in 0.
  - After N steps, go to DONE.
- N = WIDTH+FRAC. With KGAIN_ROUND_EN defined, N = WIDTH+FRAC+1 (see Configuration).
- Because p <= s, the quotient is <= 1 << FRAC. It always fits in WIDTH bits when FRAC < WIDTH, so no saturation is needed.
- DONE:
  - out_valid = 1; out_k and out_dz hold steady.
  - On out_ready, go to IDLE and clear out_valid.
- Inputs are ignored outside IDLE. p and r may change freely after they are accepted.
- Reset while rst = 0 at a clock edge, including mid-division:
  - state goes to IDLE, out_valid = 0, out_k = 0, out_dz = 0, and all internal registers clear.
  - The in-flight operation is discarded.

## Timing

- Reset values: out_valid = 0, out_k = 0, out_dz = 0. in_ready = 1 from the first cycle rst is high, because the state is IDLE.
- Let E0 be the accept edge (in_valid & in_ready).
- Normal path: out_valid rises at edge E0+1+N. That is 49 cycles for 32/16, or 50 with rounding.
- Divide-by-zero path: out_valid rises at edge E0+2.
- Output: out_valid stays high until the first edge where out_ready = 1; it clears at that edge.
- Back-to-back:
  - in_ready rises in the cycle after the out_ready edge.
  - The next accept happens at the earliest one cycle after the handshake.
  - No overlap of operations; one result is outstanding at a time.

## Configuration

- KGAIN_ROUND_EN defined:
  - One extra quotient bit is computed.
  - out_k = (q + 1) >> 1, which rounds half-up.
  - Latency +1 cycle.
- KGAIN_ROUND_EN undefined: the quotient is truncated toward zero.

## Structure

- Package kalman_pkg holds:
  - the state enum (IDLE, SUM, DIV, DONE);
  - the default WIDTH and FRAC;
  - localparam ONE = 1 << FRAC;
  - the iteration-count width function clog2(WIDTH+FRAC+2).
- Sub-module div_step: a combinational single restoring step.
  - Inputs: remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once inside kalman_gain.
- The existing add unit may compute s. It must be widened to WIDTH+1 bits.

## Test plan

All values use WIDTH = 32, FRAC = 16.

- Basic ratios:
  - p=1, r=1 → out_k = 0x0000_8000, out_dz = 0.
  - p=3, r=1 → 0x0000_C000.
  - out_valid exactly 49 cycles after accept.
- Zero numerator and divide-by-zero:
  - p=0, r=5 → out_k = 0.
  - p=0, r=0 → out_k = 0, out_dz = 1, out_valid 2 cycles after accept.
- Sum wide-carry: p = r = 0xFFFF_FFFF → 0x0000_8000, proving the 33-bit sum.
- Rounding:
  - p=2, r=1 → 0x0000_AAAA truncated, or 0x0000_AAAB with KGAIN_ROUND_EN.
  - p=1, r=2 → 0x0000_5555 in both builds.
- Handshake backpressure: hold out_ready = 0 for 10 cycles in DONE → out_valid and out_k stable and in_ready = 0. Then raise out_ready → in_ready = 1 the next cycle, and a second operand pair is accepted correctly.
- Mid-operation reset: drive rst = 0 for one edge at DIV step 20 → out_valid = 0, out_k = 0, in_ready = 1 after release. A fresh p=1, r=3 then yields 0x0000_4000.
